// File: rtl/cr_huf_comp_st_reader_pkg.sv
// Shared types and constants for the Huffman compressor symbol-table reader.
// Optional feature macro: CR_HUF_COMP_ST_READER_XTR_CHK_EN (extra-bit total check).
package cr_huf_comp_st_reader_pkg;

    localparam int CREOLE_HC_SEQID_WIDTH              = 6;
    localparam int CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE = 12;
    localparam int ST_XTR_W                           = CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE + 1;

    localparam int ST_EXTRA_W     = 13;
    localparam int ST_EXTRA_LEN_W = 4;
    localparam int ST_SYMBOL_W    = 10;

    localparam int ST_READER_DEPTH_DFLT = 584;
    localparam int ST_READER_PTR_W      = $clog2(ST_READER_DEPTH_DFLT + 1);

    // End-of-block classification carried with each table.
    typedef enum logic [1:0] {
        MIDDLE    = 2'd0,
        PASS_THRU = 2'd1,
        EOB       = 2'd2,
        EOF       = 2'd3
    } e_pipe_eob;

    // One stored symbol-table entry.
    typedef struct packed {
        logic [ST_EXTRA_W-1:0]     extra;
        logic [ST_EXTRA_LEN_W-1:0] extra_length;
        logic [ST_SYMBOL_W-1:0]    symbol;
        logic                      val;
    } s_st_sym_buf_intf;

    // Reader control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } e_st_reader_state;

    // Saturating accumulate of one entry's extra-bit length.
    function automatic logic [ST_XTR_W-1:0] xtr_sat_add(
        input logic [ST_XTR_W-1:0]       acc,
        input logic [ST_EXTRA_LEN_W-1:0] len
    );
        logic [ST_XTR_W:0] sum;
        sum = {1'b0, acc} + {{(ST_XTR_W + 1 - ST_EXTRA_LEN_W){1'b0}}, len};
        if (sum[ST_XTR_W]) begin
            xtr_sat_add = {ST_XTR_W{1'b1}};
        end else begin
            xtr_sat_add = sum[ST_XTR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cr_huf_comp_st_reader_oreg.sv
// Output holding register: presents one entry with valid/last and holds it
// stable until the consumer accepts it.
module cr_huf_comp_st_reader_oreg
    import cr_huf_comp_st_reader_pkg::*;
(
    input  logic             clk_gated,
    input  logic             rst_n,
    input  logic             i_load,
    input  s_st_sym_buf_intf i_sym,
    input  logic             i_last,
    input  logic             i_rdy,
    output logic             o_val,
    output s_st_sym_buf_intf o_sym,
    output logic             o_last,
    output logic             o_xfer
);

    logic             r_val;
    s_st_sym_buf_intf r_sym;
    logic             r_last;

    // Load a new entry, drop valid once accepted, otherwise hold.
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= 1'b0;
            r_sym  <= '0;
            r_last <= 1'b0;
        end else if (i_load) begin
            r_val  <= 1'b1;
            r_sym  <= i_sym;
            r_last <= i_last;
        end else if (r_val && i_rdy) begin
            r_val  <= 1'b0;
        end else begin
            r_val  <= r_val;
        end
    end

    assign o_val  = r_val;
    assign o_sym  = r_sym;
    assign o_last = r_last;
    assign o_xfer = r_val & i_rdy;

endmodule

// File: rtl/cr_huf_comp_st_reader.sv
// Symbol-table reader: on a full table, latches sideband, streams entries
// 0..cnt-1 one per cycle over valid/ready, then pulses read-done to the queue.
// Optional feature macro: CR_HUF_COMP_ST_READER_XTR_CHK_EN adds a saturating
// extra-bit accumulator compared against st_extra_size_store at DONE.
module cr_huf_comp_st_reader
    import cr_huf_comp_st_reader_pkg::*;
#(
    parameter int DAT_WIDTH              = 10,
    parameter int MAX_SYMBOL_TABLE_DEPTH = 584
) (
    input  logic                                           clk_gated,
    input  logic                                           rst_n,
    input  logic                                           sym_buf_full,
    input  s_st_sym_buf_intf                               sym_buf [MAX_SYMBOL_TABLE_DEPTH],
    input  logic [$clog2(MAX_SYMBOL_TABLE_DEPTH+1)-1:0]    sym_buf_wr_ptr,
    input  logic [ST_XTR_W-1:0]                            st_extra_size_store,
    input  logic [CREOLE_HC_SEQID_WIDTH-1:0]               st_seq_id,
    input  e_pipe_eob                                      st_eob,
    input  logic                                           st_deflate_store,
    input  logic                                           st_build_error,
    input  logic                                           sa_sym_rdy,
    output logic                                           sa_sym_val,
    output s_st_sym_buf_intf                               sa_sym,
    output logic                                           sa_sym_last,
    output logic [CREOLE_HC_SEQID_WIDTH-1:0]               sa_seq_id,
    output e_pipe_eob                                      sa_eob,
    output logic                                           sa_deflate,
    output logic                                           sa_build_error,
    output logic                                           sa_st_read_done,
    output logic                                           sa_extra_size_err
);

    localparam int              PTR_W   = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1);
    localparam logic [PTR_W-1:0] MAX_CNT = PTR_W'(MAX_SYMBOL_TABLE_DEPTH);
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

    // The pointer domain must be able to address every entry.
    if (DAT_WIDTH < PTR_W) begin : g_cfg_chk
        $error("cr_huf_comp_st_reader: DAT_WIDTH too small for MAX_SYMBOL_TABLE_DEPTH");
    end

    e_st_reader_state              r_state;
    e_st_reader_state              w_state_nxt;
    logic [PTR_W-1:0]              r_rd_ptr;
    logic [PTR_W-1:0]              r_cnt;
    logic [PTR_W-1:0]              w_cnt_in;
    logic [PTR_W-1:0]              w_ptr_plus1;
    logic [PTR_W-1:0]              w_oreg_idx;
    logic                          w_oreg_load;
    logic                          w_oreg_last;
    logic                          w_latch;
    logic                          w_ptr_inc;
    logic                          w_xfer;
    logic [CREOLE_HC_SEQID_WIDTH-1:0] r_seq_id;
    e_pipe_eob                     r_eob;
    logic                          r_deflate;
    logic                          r_build_error;
    logic                          r_st_read_done;

    // Oversized entry counts are clamped to the buffer depth so the pointer never wraps.
    assign w_cnt_in    = (sym_buf_wr_ptr > MAX_CNT) ? MAX_CNT : sym_buf_wr_ptr;
    assign w_ptr_plus1 = r_rd_ptr + ONE;

    // State register.
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; full is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_oreg_load = 1'b0;
        w_oreg_idx  = r_rd_ptr;
        w_oreg_last = 1'b0;
        w_latch     = 1'b0;
        w_ptr_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (sym_buf_full) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_latch = 1'b1;
                if ((w_cnt_in == '0) || st_build_error) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = STREAM;
                    w_oreg_load = 1'b1;
                    w_oreg_idx  = '0;
                    w_oreg_last = (w_cnt_in == ONE);
                end
            end
            STREAM: begin
                if (w_xfer && sa_sym_last) begin
                    w_state_nxt = DONE;
                end else if (w_xfer) begin
                    w_oreg_load = 1'b1;
                    w_oreg_idx  = w_ptr_plus1;
                    w_oreg_last = (w_ptr_plus1 == (r_cnt - ONE));
                    w_ptr_inc   = 1'b1;
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch per-table sideband at LOAD and advance the read pointer on transfers.
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_id      <= '0;
            r_eob         <= MIDDLE;
            r_deflate     <= 1'b0;
            r_build_error <= 1'b0;
            r_cnt         <= '0;
            r_rd_ptr      <= '0;
        end else if (w_latch) begin
            r_seq_id      <= st_seq_id;
            r_eob         <= st_eob;
            r_deflate     <= st_deflate_store;
            r_build_error <= st_build_error;
            r_cnt         <= w_cnt_in;
            r_rd_ptr      <= '0;
        end else if (w_ptr_inc) begin
            r_rd_ptr      <= w_ptr_plus1;
        end else begin
            r_rd_ptr      <= r_rd_ptr;
        end
    end

    // Read-done is high for exactly the one cycle spent in DONE.
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_st_read_done <= 1'b0;
        end else begin
            r_st_read_done <= (w_state_nxt == DONE);
        end
    end

    cr_huf_comp_st_reader_oreg u_oreg (
        .clk_gated (clk_gated),
        .rst_n     (rst_n),
        .i_load    (w_oreg_load),
        .i_sym     (sym_buf[w_oreg_idx]),
        .i_last    (w_oreg_last),
        .i_rdy     (sa_sym_rdy),
        .o_val     (sa_sym_val),
        .o_sym     (sa_sym),
        .o_last    (sa_sym_last),
        .o_xfer    (w_xfer)
    );

`ifdef CR_HUF_COMP_ST_READER_XTR_CHK_EN
    logic [ST_XTR_W-1:0] r_xtr_acc;
    logic [ST_XTR_W-1:0] w_xtr_acc_nxt;
    logic                w_build_error_nxt;
    logic                r_xtr_err;

    // Accumulator update; the build-error view follows the value latched at LOAD.
    always_comb begin
        w_xtr_acc_nxt     = r_xtr_acc;
        w_build_error_nxt = r_build_error;
        if (w_latch) begin
            w_xtr_acc_nxt     = '0;
            w_build_error_nxt = st_build_error;
        end else if (w_xfer) begin
            w_xtr_acc_nxt = xtr_sat_add(r_xtr_acc, sa_sym.extra_length);
        end else begin
            w_xtr_acc_nxt = r_xtr_acc;
        end
    end

    // Accumulate transferred extra bits; flag a mismatch alongside read-done.
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_xtr_acc <= '0;
            r_xtr_err <= 1'b0;
        end else begin
            r_xtr_acc <= w_xtr_acc_nxt;
            r_xtr_err <= (w_state_nxt == DONE) &&
                         (w_xtr_acc_nxt != st_extra_size_store) &&
                         !w_build_error_nxt;
        end
    end

    assign sa_extra_size_err = r_xtr_err;
`else
    logic w_unused_xtr;
    assign w_unused_xtr      = ^st_extra_size_store;
    assign sa_extra_size_err = 1'b0;
`endif

    assign sa_seq_id       = r_seq_id;
    assign sa_eob          = r_eob;
    assign sa_deflate      = r_deflate;
    assign sa_build_error  = r_build_error;
    assign sa_st_read_done = r_st_read_done;

endmodule

// File: tb/tb_cr_huf_comp_st_reader.sv
// Scoreboard bench for cr_huf_comp_st_reader: the stimulus side computes each
// table's expected entry stream and done record; a monitor checks them.
module tb_cr_huf_comp_st_reader;
    import cr_huf_comp_st_reader_pkg::*;

    localparam int DEPTH = 584;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int XMAX  = (1 << ST_XTR_W) - 1;
`ifdef CR_HUF_COMP_ST_READER_XTR_CHK_EN
    localparam bit XEN = 1'b1;
`else
    localparam bit XEN = 1'b0;
`endif

    logic                             clk_gated = 1'b0;
    logic                             rst_n = 1'b0;
    logic                             sym_buf_full = 1'b0;
    s_st_sym_buf_intf                 sym_buf [DEPTH];
    logic [PW-1:0]                    sym_buf_wr_ptr = '0;
    logic [ST_XTR_W-1:0]              st_extra_size_store = '0;
    logic [CREOLE_HC_SEQID_WIDTH-1:0] st_seq_id = '0;
    e_pipe_eob                        st_eob = MIDDLE;
    logic                             st_deflate_store = 1'b0;
    logic                             st_build_error = 1'b0;
    logic                             sa_sym_rdy = 1'b0;
    logic                             sa_sym_val;
    s_st_sym_buf_intf                 sa_sym;
    logic                             sa_sym_last;
    logic [CREOLE_HC_SEQID_WIDTH-1:0] sa_seq_id;
    e_pipe_eob                        sa_eob;
    logic                             sa_deflate;
    logic                             sa_build_error;
    logic                             sa_st_read_done;
    logic                             sa_extra_size_err;

    cr_huf_comp_st_reader #(.DAT_WIDTH(10), .MAX_SYMBOL_TABLE_DEPTH(DEPTH)) dut (
        .clk_gated(clk_gated), .rst_n(rst_n), .sym_buf_full(sym_buf_full),
        .sym_buf(sym_buf), .sym_buf_wr_ptr(sym_buf_wr_ptr),
        .st_extra_size_store(st_extra_size_store), .st_seq_id(st_seq_id),
        .st_eob(st_eob), .st_deflate_store(st_deflate_store),
        .st_build_error(st_build_error), .sa_sym_rdy(sa_sym_rdy),
        .sa_sym_val(sa_sym_val), .sa_sym(sa_sym), .sa_sym_last(sa_sym_last),
        .sa_seq_id(sa_seq_id), .sa_eob(sa_eob), .sa_deflate(sa_deflate),
        .sa_build_error(sa_build_error), .sa_st_read_done(sa_st_read_done),
        .sa_extra_size_err(sa_extra_size_err)
    );

    always #5 clk_gated = ~clk_gated;

    typedef struct packed {
        s_st_sym_buf_intf sym;
        logic             last;
    } exp_ent_t;

    typedef struct packed {
        logic [CREOLE_HC_SEQID_WIDTH-1:0] seq;
        e_pipe_eob                        eob;
        logic                             defl;
        logic                             berr;
        logic                             xerr;
    } exp_done_t;

    exp_ent_t  ent_q[$];
    exp_done_t done_q[$];
    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0,1,1

    // Ready generator.
    initial begin : rdy_drv
        int pc;
        pc = 0;
        forever begin
            @(posedge clk_gated);
            #1;
            if (rdy_mode == 0) begin
                sa_sym_rdy = 1'b1;
            end else if (rdy_mode == 1) begin
                sa_sym_rdy = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            end else begin
                sa_sym_rdy = ((pc % 5) == 0 || (pc % 5) >= 3) ? 1'b1 : 1'b0;
                pc++;
            end
        end
    end

    // Monitor: pops expectations on every transfer and every done pulse.
    initial begin : mon
        logic             stall;
        s_st_sym_buf_intf psym;
        logic             plast;
        exp_ent_t         e;
        exp_done_t        d;
        stall = 1'b0;
        psym  = '0;
        plast = 1'b0;
        forever begin
            @(negedge clk_gated);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    tests++;
                    if (!(sa_sym_val === 1'b1 && sa_sym === psym && sa_sym_last === plast)) begin
                        fails++;
                        $display("FAIL hold_stable: got val=%0b sym=%h last=%0b, want val=1 sym=%h last=%0b",
                                 sa_sym_val, sa_sym, sa_sym_last, psym, plast);
                    end
                end
                if (sa_sym_val && sa_sym_rdy) begin
                    xfer_cnt++;
                    tests++;
                    if (ent_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_entry: got sym=%h last=%0b, want none", sa_sym, sa_sym_last);
                    end else begin
                        e = ent_q.pop_front();
                        if (sa_sym !== e.sym || sa_sym_last !== e.last) begin
                            fails++;
                            $display("FAIL entry: got sym=%h last=%0b, want sym=%h last=%0b",
                                     sa_sym, sa_sym_last, e.sym, e.last);
                        end
                    end
                end
                if (sa_st_read_done) begin
                    tests++;
                    if (done_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done: got done=1, want 0");
                    end else begin
                        d = done_q.pop_front();
                        if (sa_seq_id !== d.seq || sa_eob !== d.eob || sa_deflate !== d.defl ||
                            sa_build_error !== d.berr || sa_extra_size_err !== d.xerr || sa_sym_val !== 1'b0) begin
                            fails++;
                            $display("FAIL done_sideband: got seq=%0d eob=%0d defl=%0b berr=%0b xerr=%0b val=%0b, want seq=%0d eob=%0d defl=%0b berr=%0b xerr=%0b val=0",
                                     sa_seq_id, sa_eob, sa_deflate, sa_build_error, sa_extra_size_err, sa_sym_val,
                                     d.seq, d.eob, d.defl, d.berr, d.xerr);
                        end
                    end
                end else if (sa_extra_size_err) begin
                    tests++;
                    fails++;
                    $display("FAIL xerr_without_done: got xerr=1, want 0");
                end
                stall = sa_sym_val && !sa_sym_rdy;
                psym  = sa_sym;
                plast = sa_sym_last;
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        logic bad;
        bad = sa_sym_val | (|sa_sym) | sa_sym_last | (|sa_seq_id) | (sa_eob != MIDDLE) |
              sa_deflate | sa_build_error | sa_st_read_done | sa_extra_size_err;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s: got val=%0b sym=%h last=%0b seq=%0d eob=%0d defl=%0b berr=%0b done=%0b xerr=%0b, want all 0 / eob=MIDDLE",
                     name, sa_sym_val, sa_sym, sa_sym_last, sa_seq_id, sa_eob, sa_deflate,
                     sa_build_error, sa_st_read_done, sa_extra_size_err);
        end
    endtask

    task automatic fill_rand();
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            sym_buf[i] = r[27:0];
        end
    endtask

    // Reference: a table yields entries 0..min(ptr,DEPTH)-1 unless empty or
    // in build error; the extra-bit total saturates at the field maximum.
    task automatic push_expect(input int nn, input bit berr);
        int        sum;
        exp_done_t d;
        sum = 0;
        if (nn > 0 && !berr) begin
            for (int i = 0; i < nn; i++) begin
                ent_q.push_back({sym_buf[i], (i == nn - 1) ? 1'b1 : 1'b0});
                sum += int'(sym_buf[i].extra_length);
            end
        end
        if (sum > XMAX) sum = XMAX;
        d.seq  = st_seq_id;
        d.eob  = st_eob;
        d.defl = st_deflate_store;
        d.berr = berr;
        d.xerr = XEN && !berr && (sum != int'(st_extra_size_store));
        done_q.push_back(d);
    endtask

    // Present one table, wait for its done pulse, then release full like the queue does.
    task automatic run_table(input int ptr, input bit berr, input int store, input int mode,
                             input bit mid_reset);
        int nn;
        int k;
        bit done_seen;
        nn = (ptr > DEPTH) ? DEPTH : ptr;
        rdy_mode            = mode;
        sym_buf_wr_ptr      = PW'(ptr);
        st_build_error      = berr;
        st_extra_size_store = ST_XTR_W'(store);
        st_seq_id           = CREOLE_HC_SEQID_WIDTH'($urandom);
        st_eob              = e_pipe_eob'($urandom_range(0, 3));
        st_deflate_store    = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
        push_expect(nn, berr);
        xfer_cnt     = 0;
        sym_buf_full = 1'b1;
        if (mid_reset) begin
            k = 0;
            while (xfer_cnt < 1 && k < 100) begin
                @(negedge clk_gated);
                #1;
                k++;
            end
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_stream_reset");
            ent_q.delete();
            done_q.delete();
            @(posedge clk_gated);
            #1;
            check_reset_outputs("reset_held");
            rst_n = 1'b1;
            push_expect(nn, berr);
            xfer_cnt = 0;
        end
        k = 0;
        done_seen = 1'b0;
        while (!done_seen && k < nn * 16 + 40) begin
            @(negedge clk_gated);
            #1;
            k++;
            done_seen = sa_st_read_done;
        end
        tests++;
        if (!done_seen) begin
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles, want done", k);
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
            ent_q.delete();
            done_q.delete();
        end else begin
            tests++;
            if (xfer_cnt != ((berr || nn == 0) ? 0 : nn)) begin
                fails++;
                $display("FAIL xfer_count: got %0d, want %0d", xfer_cnt, (berr || nn == 0) ? 0 : nn);
            end
            if (mode == 0 && !mid_reset) begin
                tests++;
                if (k != ((berr || nn == 0) ? 3 : nn + 3)) begin
                    fails++;
                    $display("FAIL latency: got %0d cycles to done, want %0d", k, (berr || nn == 0) ? 3 : nn + 3);
                end
            end
        end
        @(posedge clk_gated);
        #1;
        sym_buf_full = 1'b0;
        repeat (3) @(posedge clk_gated);
        #1;
        tests++;
        if (ent_q.size() != 0 || done_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expect: got %0d entries %0d dones pending, want 0 0", ent_q.size(), done_q.size());
            ent_q.delete();
            done_q.delete();
        end
    endtask

    initial begin : stim
        int sum;
        fill_rand();
        repeat (3) @(posedge clk_gated);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk_gated);
        #1;
        check_reset_outputs("idle_after_reset");

        // Five entries, continuous ready.
        for (int i = 0; i < 5; i++) sym_buf[i].symbol = ST_SYMBOL_W'(10 + i);
        run_table(5, 1'b0, 0, 0, 1'b0);
        // Three entries, toggling ready.
        fill_rand();
        run_table(3, 1'b0, 0, 2, 1'b0);
        // Empty table and build-error table.
        run_table(0, 1'b0, 0, 0, 1'b0);
        run_table(7, 1'b1, 0, 0, 1'b0);
        // Single entry: first entry is also last.
        fill_rand();
        run_table(1, 1'b0, int'(sym_buf[0].extra_length), 0, 1'b0);
        // Extra-bit total 3+4+5 against 11 and 12.
        sym_buf[0].extra_length = 4'd3;
        sym_buf[1].extra_length = 4'd4;
        sym_buf[2].extra_length = 4'd5;
        run_table(3, 1'b0, 11, 0, 1'b0);
        run_table(3, 1'b0, 12, 1, 1'b0);
        // Reset during the second transfer, then restart from entry 0.
        fill_rand();
        run_table(6, 1'b0, 0, 0, 1'b1);
        // Over-range count clamps to depth; extra total saturates.
        for (int i = 0; i < DEPTH; i++) sym_buf[i].extra_length = 4'd15;
        run_table((1 << PW) - 1, 1'b0, XMAX, 0, 1'b0);
        // Randomized tables.
        for (int t = 0; t < 20; t++) begin
            int n;
            bit be;
            fill_rand();
            n  = $urandom_range(0, 12);
            be = ($urandom_range(0, 7) == 0);
            sum = 0;
            for (int i = 0; i < n; i++) sum += int'(sym_buf[i].extra_length);
            if ($urandom_range(0, 1) == 1) sum = $urandom_range(0, 200);
            run_table(n, be, sum, $urandom_range(0, 2), 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
